// File: rtl/encoder_scheduler_pkg.sv
// Shared step-decode codes and the channel-index width helper for the encoder scheduler.
package encoder_sched_pkg;

  // Key layout is {sa, pa, sb, pb}: current and previous synced level of each phase.
  localparam logic [3:0] STEP_UP_A = 4'b1000;
  localparam logic [3:0] STEP_UP_B = 4'b0111;
  localparam logic [3:0] STEP_DN_A = 4'b0010;
  localparam logic [3:0] STEP_DN_B = 4'b1101;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encoder_scheduler_if.sv
// Pin/config/update bundle between the encoder scheduler and its host.
interface encoder_scheduler_if
  import encoder_sched_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int WIDTH = 8
);
  localparam int CHW = chw(NCH);

  logic [NCH-1:0]       a;
  logic [NCH-1:0]       b;
  logic                 cfg_we;
  logic [CHW-1:0]       cfg_ch;
  logic [WIDTH-1:0]     cfg_inc;
  logic                 cfg_clr;
  logic [NCH*WIDTH-1:0] value;
  logic                 upd_valid;
  logic [CHW-1:0]       upd_ch;
  logic [NCH-1:0]       err;

  modport master (
    output a, b, cfg_we, cfg_ch, cfg_inc, cfg_clr,
    input  value, upd_valid, upd_ch, err
  );

  modport slave (
    input  a, b, cfg_we, cfg_ch, cfg_inc, cfg_clr,
    output value, upd_valid, upd_ch, err
  );

endinterface

// File: rtl/encoder_scheduler_alu.sv
// Combinational quadrature step decode and accumulate for one channel slot.
// Define ENC_SAT_EN to clamp at the unsigned range limits instead of wrapping.
module enc_step_alu
  import encoder_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       key_i,
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] inc_i,
  output logic [WIDTH-1:0] new_o,
  output logic             changed_o,
  output logic             err_hit_o
);

  function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] old_v,
                                                input logic [WIDTH-1:0] inc_v);
`ifdef ENC_SAT_EN
    logic [WIDTH:0] sum;
    sum = {1'b0, old_v} + {1'b0, inc_v};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    return old_v + inc_v;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] sub_step(input logic [WIDTH-1:0] old_v,
                                                input logic [WIDTH-1:0] inc_v);
`ifdef ENC_SAT_EN
    return (inc_v > old_v) ? '0 : old_v - inc_v;
`else
    return old_v - inc_v;
`endif
  endfunction

  always_comb begin
    new_o = old_i;
    case (key_i)
      STEP_UP_A, STEP_UP_B: new_o = add_step(old_i, inc_i);
      STEP_DN_A, STEP_DN_B: new_o = sub_step(old_i, inc_i);
      default:              new_o = old_i;
    endcase
  end

  // A clamped step or a zero increment leaves the value as it was; that is not an update.
  assign changed_o = (new_o != old_i);
  assign err_hit_o = (key_i[3] ^ key_i[2]) & (key_i[1] ^ key_i[0]);

endmodule

// File: rtl/encoder_scheduler.sv
// Round-robin scheduler sharing one quadrature decode/accumulate datapath across NCH encoders.
// Optional ENC_SAT_EN (see enc_step_alu) turns wrap-around arithmetic into saturation.
module encoder_scheduler
  import encoder_sched_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int WIDTH   = 8,
  parameter int INC_RST = 1
) (
  input  logic         clk,
  input  logic         reset,
  encoder_scheduler_if.slave bus
);
  localparam int CHW = chw(NCH);

  logic [NCH-1:0]   a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [NCH-1:0]   pa_q, pa_d, pb_q, pb_d;
  logic [NCH-1:0]   err_q, err_d;
  logic [WIDTH-1:0] value_q [NCH];
  logic [WIDTH-1:0] value_d [NCH];
  logic [WIDTH-1:0] inc_q   [NCH];
  logic [WIDTH-1:0] inc_d   [NCH];
  logic [CHW-1:0]   slot_q, slot_d;
  logic             upd_valid_q, upd_valid_d;
  logic [CHW-1:0]   upd_ch_q, upd_ch_d;

  logic [3:0]       key;
  logic [WIDTH-1:0] alu_new;
  logic             alu_changed, alu_err;
  logic             cfg_hit;

  assign key = {a_s2_q[slot_q], pa_q[slot_q], b_s2_q[slot_q], pb_q[slot_q]};

  enc_step_alu #(.WIDTH(WIDTH)) u_alu (
    .key_i    (key),
    .old_i    (value_q[slot_q]),
    .inc_i    (inc_q[slot_q]),
    .new_o    (alu_new),
    .changed_o(alu_changed),
    .err_hit_o(alu_err)
  );

  assign cfg_hit = bus.cfg_we && (int'(bus.cfg_ch) < NCH);

  always_comb begin
    value_d     = value_q;
    inc_d       = inc_q;
    err_d       = err_q;
    pa_d        = pa_q;
    pb_d        = pb_q;
    upd_valid_d = 1'b0;
    upd_ch_d    = upd_ch_q;
    slot_d      = (slot_q == CHW'(NCH - 1)) ? '0 : slot_q + CHW'(1);

    pa_d[slot_q] = a_s2_q[slot_q];
    pb_d[slot_q] = b_s2_q[slot_q];
    if (alu_changed) begin
      value_d[slot_q] = alu_new;
      upd_valid_d     = 1'b1;
      upd_ch_d        = slot_q;
    end
    if (alu_err) err_d[slot_q] = 1'b1;

    // Config lands after the decode so the slot step uses the old inc and a clear overrides it.
    if (cfg_hit) begin
      inc_d[bus.cfg_ch] = bus.cfg_inc;
      if (bus.cfg_clr) begin
        value_d[bus.cfg_ch] = '0;
        err_d[bus.cfg_ch]   = 1'b0;
        if (bus.cfg_ch == slot_q) begin
          upd_valid_d = 1'b0;
          upd_ch_d    = upd_ch_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1_q      <= '0;
      a_s2_q      <= '0;
      b_s1_q      <= '0;
      b_s2_q      <= '0;
      pa_q        <= '0;
      pb_q        <= '0;
      err_q       <= '0;
      value_q     <= '{default: '0};
      inc_q       <= '{default: WIDTH'(INC_RST)};
      slot_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      a_s1_q      <= bus.a;
      a_s2_q      <= a_s1_q;
      b_s1_q      <= bus.b;
      b_s2_q      <= b_s1_q;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      err_q       <= err_d;
      value_q     <= value_d;
      inc_q       <= inc_d;
      slot_q      <= slot_d;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_value
    assign bus.value[i*WIDTH +: WIDTH] = value_q[i];
  end

  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_ch    = upd_ch_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_encoder_scheduler.sv
// Directed, table-driven bench for encoder_scheduler (NCH=3, WIDTH=8, INC_RST=1).
module tb_encoder_scheduler;
  import encoder_sched_pkg::*;

  localparam int NCH   = 3;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  encoder_scheduler_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  encoder_scheduler #(.NCH(NCH), .WIDTH(WIDTH), .INC_RST(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Mirrors the slot pointer: between edges, cyc % NCH is the slot decoded at the next edge.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int               ch;
    logic             va;
    logic             vb;
    logic [WIDTH-1:0] exp_val;
    int               exp_upd;
    logic             exp_err;
  } vec_t;

  vec_t             tbl[$];
  logic [WIDTH-1:0] mdl [NCH];
  logic [NCH-1:0]   mdl_err;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int ch, input logic va, input logic vb,
                     input logic [WIDTH-1:0] ev, input int eu, input logic ee);
    vec_t v;
    v.ch = ch; v.va = va; v.vb = vb; v.exp_val = ev; v.exp_upd = eu; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  function automatic logic [NCH*WIDTH-1:0] mdl_bus();
    logic [NCH*WIDTH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*WIDTH +: WIDTH] = mdl[i];
    return r;
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    int   upd;
    int   bad;
    v = tbl[idx];
    upd = 0;
    bad = 0;
    bus.a[v.ch] = v.va;
    bus.b[v.ch] = v.vb;
    repeat (6) begin
      step();
      if (bus.upd_valid) begin
        upd++;
        if (int'(bus.upd_ch) != v.ch) bad++;
      end
    end
    mdl[v.ch]     = v.exp_val;
    mdl_err[v.ch] = v.exp_err;
    check($sformatf("v%0d value", idx), bus.value, mdl_bus());
    check($sformatf("v%0d upd_count", idx), upd, v.exp_upd);
    check($sformatf("v%0d upd_ch_wrong", idx), bad, 0);
    check($sformatf("v%0d err", idx), bus.err, mdl_err);
  endtask

  task automatic cfg_write(input int ch, input logic [WIDTH-1:0] inc, input logic clr);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = ch[1:0];
    bus.cfg_inc = inc;
    bus.cfg_clr = clr;
    step();
    bus.cfg_we  = 1'b0;
    bus.cfg_clr = 1'b0;
  endtask

  task automatic wait_slot(input int ch);
    int n;
    n = 0;
    while ((cyc % NCH) != ch && n < 2 * NCH) begin
      step();
      n++;
    end
    check("slot_wait", cyc % NCH, ch);
  endtask

  initial begin
    int upd;
    bus.a = '0; bus.b = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_inc = '0; bus.cfg_clr = 1'b0;

    add(1, 1, 0, 8'd1, 1, 0);     // 0: A rises, B low -> up
    add(1, 1, 1, 8'd1, 0, 0);     // 1: 1110, no step
    add(1, 1, 0, 8'd0, 1, 0);     // 2: 1101 -> down
    add(1, 0, 0, 8'd0, 0, 0);     // 3: 0100, no step
`ifdef ENC_SAT_EN
    add(0, 0, 1, 8'd0, 0, 0);     // 4: down from 0 clamps
    add(0, 0, 0, 8'd0, 0, 0);     // 5
`else
    add(0, 0, 1, 8'd255, 1, 0);   // 4: down from 0 wraps
    add(0, 0, 0, 8'd255, 0, 0);   // 5
`endif
    add(2, 1, 0, 8'd5, 1, 0);     // 6..13: four up-steps of 5 on ch2
    add(2, 1, 1, 8'd5, 0, 0);
    add(2, 0, 1, 8'd10, 1, 0);
    add(2, 0, 0, 8'd10, 0, 0);
    add(2, 1, 0, 8'd15, 1, 0);
    add(2, 1, 1, 8'd15, 0, 0);
    add(2, 0, 1, 8'd20, 1, 0);
    add(2, 0, 0, 8'd20, 0, 0);
    add(2, 1, 0, 8'd25, 1, 0);    // 14: inc still 5 after ignored write
`ifdef ENC_SAT_EN
    add(0, 1, 0, 8'd1, 1, 0);     // 15
    add(0, 0, 1, 8'd1, 0, 1);     // 16: both phases flip
    add(0, 0, 0, 8'd1, 0, 1);     // 17: err sticky
`else
    add(0, 1, 0, 8'd0, 1, 0);     // 15: 255+1 wraps
    add(0, 0, 1, 8'd0, 0, 1);     // 16: both phases flip
    add(0, 0, 0, 8'd0, 0, 1);     // 17: err sticky
`endif
    add(1, 1, 1, 8'd1, 0, 0);     // 18
    add(1, 0, 1, 8'd8, 1, 0);     // 19: 0111 with new inc=7
    add(1, 0, 0, 8'd8, 0, 0);     // 20

    // Reset held while the pins toggle
    repeat (5) begin
      bus.a = ~bus.a;
      bus.b = bus.b ^ 3'b101;
      step();
      check("rst value", bus.value, 0);
      check("rst err", bus.err, 0);
      check("rst upd_valid", bus.upd_valid, 0);
    end
    bus.a = '0; bus.b = '0;
    step();
    reset = 1'b0;
    repeat (3) step();
    check("post_rst upd_ch", bus.upd_ch, 0);
    check("post_rst value", bus.value, 0);
    for (int i = 0; i < NCH; i++) mdl[i] = '0;
    mdl_err = '0;

    for (int i = 0; i <= 5; i++) run_vec(i);
    cfg_write(2, 8'd5, 1'b0);
    for (int i = 6; i <= 13; i++) run_vec(i);

    cfg_write(3, 8'd9, 1'b1);
    repeat (2) step();
    check("ignored cfg value", bus.value, mdl_bus());
    check("ignored cfg err", bus.err, mdl_err);
    for (int i = 14; i <= 17; i++) run_vec(i);

    cfg_write(0, 8'd1, 1'b1);
    mdl[0] = '0; mdl_err[0] = 1'b0;
    check("clr ch0 value", bus.value, mdl_bus());
    check("clr ch0 err", bus.err, mdl_err);

    // Inc rewrite in ch1's own slot: step uses the old inc
    bus.a[1] = 1'b1;
    step(); step();
    wait_slot(1);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_inc = 8'd7; bus.cfg_clr = 1'b0;
    step();
    bus.cfg_we = 1'b0;
    mdl[1] = 8'd1;
    check("slotcfg upd_valid", bus.upd_valid, 1);
    check("slotcfg upd_ch", bus.upd_ch, 1);
    check("slotcfg value", bus.value, mdl_bus());
    for (int i = 18; i <= 20; i++) run_vec(i);

    // Clear in ch1's step slot wins over the step
    bus.a[1] = 1'b1;
    step(); step();
    wait_slot(1);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_inc = 8'd1; bus.cfg_clr = 1'b1;
    step();
    bus.cfg_we = 1'b0; bus.cfg_clr = 1'b0;
    mdl[1] = '0;
    check("slotclr upd_valid", bus.upd_valid, 0);
    check("slotclr value", bus.value, mdl_bus());
    upd = 0;
    repeat (5) begin
      step();
      if (bus.upd_valid) upd++;
    end
    check("slotclr later upd", upd, 0);
    check("slotclr later value", bus.value, mdl_bus());

    // Asynchronous reset mid-operation clears immediately
    step();
    reset = 1'b1;
    #1;
    check("midrst value", bus.value, 0);
    check("midrst err", bus.err, 0);
    check("midrst upd_valid", bus.upd_valid, 0);
    step();
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
